seq_detect_ctrl: RTL and testbench



---
 rtl/seq_detect_ctrl.sv | 127 ++++++++++++
 tb/tb_seq_detect_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// Programmable serial bit-pattern detector: host config port, start/abort FSM,
// same-cycle Mealy match pulse, saturating match counter and target-based stop.
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               abort,
  input  logic               in_valid,
  input  logic               in,
  output logic               out,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int DEF_LEN = (MAX_LEN < 3) ? MAX_LEN : 3;
  localparam logic [MAX_LEN:0] ONE = 1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [MAX_LEN-1:0]   r_pattern;
  logic [LEN_W-1:0]     r_len;
  logic                 r_overlap;
  logic [CNT_W-1:0]     r_target;
  logic [MAX_LEN-1:0]   r_hist;
  logic [LEN_W-1:0]     r_fill;
  logic [CNT_W-1:0]     r_count;

  logic                 w_cfg_acc;
  logic [LEN_W-1:0]     w_cfg_len_clamped;
  logic [LEN_W-1:0]     w_eff_len;
  logic                 w_arm;
  logic [MAX_LEN:0]     w_mask;
  logic [MAX_LEN:0]     w_window;
  logic [LEN_W:0]       w_fill_inc;
  logic [LEN_W-1:0]     w_fill_sat;
  logic [CNT_W:0]       w_cnt_inc;
  logic                 w_match;
  logic                 w_hit_target;

  assign w_cfg_acc         = cfg_valid && cfg_ready;
  assign w_cfg_len_clamped = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
  assign w_eff_len         = w_cfg_acc ? w_cfg_len_clamped : r_len;
  assign w_arm             = start && (r_state != S_RUN) && (w_eff_len != '0);

  // Window is history plus the bit arriving now; mask keeps only the low len bits.
  assign w_mask     = (ONE << r_len) - ONE;
  assign w_window   = {r_hist, in};
  assign w_fill_inc = {1'b0, r_fill} + (LEN_W+1)'(1);
  assign w_fill_sat = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : w_fill_inc[LEN_W-1:0];
  assign w_cnt_inc  = {1'b0, r_count} + (CNT_W+1)'(1);

  assign w_match = (r_state == S_RUN) && in_valid && !abort &&
                   (w_fill_inc >= {1'b0, r_len}) &&
                   ((w_window & w_mask) == ({1'b0, r_pattern} & w_mask));
  assign w_hit_target = w_match && (r_target != '0) && (w_cnt_inc == {1'b0, r_target});

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (w_arm) w_state_nxt = S_RUN;
        S_RUN:          if (w_hit_target) w_state_nxt = S_DONE;
        default:        w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pattern <= MAX_LEN'(5);
      r_len     <= LEN_W'(DEF_LEN);
      r_overlap <= 1'b1;
      r_target  <= '0;
      r_hist    <= '0;
      r_fill    <= '0;
      r_count   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cfg_acc) begin
        r_pattern <= cfg_pattern;
        r_len     <= w_cfg_len_clamped;
        r_overlap <= cfg_overlap;
        r_target  <= cfg_target;
      end
      if (abort) begin
        r_hist <= '0;
        r_fill <= '0;
      end else if (w_arm) begin
        r_hist  <= '0;
        r_fill  <= '0;
        r_count <= '0;
      end else if ((r_state == S_RUN) && in_valid) begin
        r_hist <= {r_hist[MAX_LEN-2:0], in};
        if (w_match) begin
          r_count <= (&r_count) ? r_count : w_cnt_inc[CNT_W-1:0];
          // Non-overlapping mode restarts the fill so stale history cannot match.
          r_fill  <= r_overlap ? w_fill_sat : '0;
        end else begin
          r_fill <= w_fill_sat;
        end
      end
    end
  end

  assign out         = w_match;
  assign match_count = r_count;
  assign cfg_ready   = (r_state != S_RUN);
  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: expected out per cycle is queued by the driver and
// popped by a negedge monitor; status outputs are checked after each scenario.
module tb_seq_detect_ctrl;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int LEN_W   = 4;

  logic               clk;
  logic               rst;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_target;
  logic               start;
  logic               abort;
  logic               in_valid;
  logic               in_b;
  logic               out_b;
  logic [CNT_W-1:0]   match_count;
  logic               busy;
  logic               done;

  int   total = 0;
  int   bad   = 0;
  logic exp_q[$];
  bit   mon_on = 0;

  seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
    .start(start), .abort(abort),
    .in_valid(in_valid), .in(in_b), .out(out_b),
    .match_count(match_count), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One clock of stimulus; the expected out for this cycle goes to the scoreboard.
  task automatic cyc(input logic cv, input logic st, input logic ab,
                     input logic v, input logic b, input logic ex);
    cfg_valid = cv; start = st; abort = ab; in_valid = v; in_b = b;
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
  endtask

  task automatic stream(input string bits, input string exps);
    for (int i = 0; i < bits.len(); i++)
      cyc(1'b0, 1'b0, 1'b0, 1'b1, bits[i] == "1", exps[i] == "1");
  endtask

  task automatic set_cfg(input logic [7:0] pat, input logic [3:0] len,
                         input logic ov, input logic [7:0] tgt);
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ov; cfg_target = tgt;
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_b = 1'b0;
    set_cfg(8'b101, 4'd3, 1'b1, 8'd0);

    fork
      forever begin
        @(negedge clk);
        if (mon_on) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_underflow actual=empty expected=entry");
          end else begin
            logic e;
            e = exp_q.pop_front();
            chk("out_pulse", int'(out_b), int'(e));
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_count", match_count, 0);
    chk("rst_out", out_b, 0);
    mon_on = 1;

    // Overlapping detection with reset-default config.
    cyc(0, 1, 0, 0, 0, 0);
    chk("ovl_busy_after_start", busy, 1);
    stream("10110101", "00100101");
    chk("ovl_count", match_count, 3);
    chk("ovl_busy", busy, 1);
    chk("ovl_done", done, 0);
    chk("ovl_cfg_ready_in_run", cfg_ready, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("abort_holds_count", match_count, 3);

    // Non-overlapping; config accepted in the same cycle as start.
    set_cfg(8'b101, 4'd3, 1'b0, 8'd0);
    cyc(1, 1, 0, 0, 0, 0);
    stream("1010101", "0010001");
    chk("novl_count", match_count, 2);
    cyc(0, 0, 1, 0, 0, 0);

    // Target stop at two matches.
    set_cfg(8'b101, 4'd3, 1'b1, 8'd2);
    cyc(1, 1, 0, 0, 0, 0);
    stream("10101101", "00101000");
    chk("tgt_done", done, 1);
    chk("tgt_busy", busy, 0);
    chk("tgt_count", match_count, 2);
    chk("tgt_cfg_ready", cfg_ready, 1);

    // Restart from DONE with target cleared; count restarts.
    set_cfg(8'b101, 4'd3, 1'b1, 8'd0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("restart_count", match_count, 0);
    chk("restart_busy", busy, 1);

    // Gapped stream: idle cycles with a toggling data line.
    cyc(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, i[0], 0);
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, ~i[0], 0);
    cyc(0, 0, 0, 1, 1, 1);
    chk("gap_count", match_count, 1);
    cyc(0, 0, 1, 0, 0, 0);

    // Abort alongside a would-be completing bit.
    cyc(0, 1, 0, 0, 0, 0);
    stream("10", "00");
    cyc(0, 0, 1, 1, 1, 0);
    chk("abort_busy", busy, 0);
    chk("abort_cfg_ready", cfg_ready, 1);
    chk("abort_done", done, 0);
    cyc(0, 1, 0, 0, 0, 0);
    stream("1", "0");
    chk("rearm_count", match_count, 0);
    cyc(0, 0, 1, 0, 0, 0);

    // Zero length: start is ignored.
    set_cfg(8'b101, 4'd0, 1'b1, 8'd0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("len0_busy_same_cycle", busy, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("len0_busy_stored", busy, 0);

    // Length 12 clamps to 8; an in-RUN config write must be refused.
    set_cfg(8'b1100_1010, 4'd12, 1'b1, 8'd0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("max_busy", busy, 1);
    chk("max_cfg_ready_run", cfg_ready, 0);
    set_cfg(8'b101, 4'd3, 1'b1, 8'd1);
    cyc(1, 0, 0, 0, 0, 0);
    stream("1100101010", "0000000100");
    chk("max_count", match_count, 1);
    chk("max_still_busy", busy, 1);

    // Synchronous reset mid-RUN restores default config.
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_count", match_count, 0);
    chk("midrst_cfg_ready", cfg_ready, 1);
    cyc(0, 1, 0, 0, 0, 0);
    stream("101", "001");
    chk("midrst_default_cfg_count", match_count, 1);

    chk("scoreboard_drained", exp_q.size(), 0);
    mon_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
